// File: rtl/gmii_mac_pkg.sv
// Shared GMII MAC definitions: state encoding, framing bytes and CRC-32 constants.
// Used by both the transmit and receive halves of the MAC.
package gmii_mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_DRAIN
    } mac_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

endpackage

// File: rtl/gmii_crc32_byte.sv
// Combinational byte-wide Ethernet CRC-32 step (reflected, LSB first).
// Shared with the receive-side FCS checker.
module gmii_crc32_byte
    import gmii_mac_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h000000, data_i};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/gmii_mac_tx.sv
// GMII transmit MAC: preamble/SFD insertion, padding, FCS append and inter-frame gap.
// Define GMII_MAC_TX_FCS_EN to build the CRC generator with the PAD and FCS states.
module gmii_mac_tx
    import gmii_mac_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned IFG_BYTES    = 12
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] txd,
    output logic       txen,
    output logic       txer,
    output logic       gtx_clk,
    output logic       busy
);

    mac_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  txd_q, txd_d;
    logic        txen_q, txen_d;
    logic        txer_q, txer_d;
    logic        busy_q;

`ifdef GMII_MAC_TX_FCS_EN
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_next;
    logic [31:0] crc_inv;
    logic [7:0]  crc_byte;
    logic [7:0]  fcs_byte;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [10:0] byte_cnt_inc;

    // Pad bytes are zeros; everything else that reaches the CRC is the accepted input byte.
    assign crc_byte     = (state_q == ST_PAD) ? 8'h00 : s_data;
    assign crc_inv      = ~crc_q;
    assign fcs_byte     = crc_inv[{cnt_q[1:0], 3'b000} +: 8];
    assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

    gmii_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (crc_byte),
        .crc_o  (crc_next)
    );
`endif

    assign s_ready = (state_q == ST_SFD) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign txd     = txd_q;
    assign txen    = txen_q;
    assign txer    = txer_q;
    assign busy    = busy_q;
    assign gtx_clk = sys_clk;

    // Outputs are registered alongside the state, so each state names the byte already on txd.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        txd_d   = 8'h00;
        txen_d  = 1'b0;
        txer_d  = 1'b0;
`ifdef GMII_MAC_TX_FCS_EN
        crc_d      = crc_q;
        byte_cnt_d = byte_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d = ST_PREAMBLE;
                    txd_d   = PREAMBLE_BYTE;
                    txen_d  = 1'b1;
                    cnt_d   = 8'd1;
                end
            end
            ST_PREAMBLE: begin
                txen_d = 1'b1;
                if (cnt_q >= 8'(PREAMBLE_LEN)) begin
                    state_d = ST_SFD;
                    txd_d   = SFD_BYTE;
                    cnt_d   = '0;
`ifdef GMII_MAC_TX_FCS_EN
                    crc_d      = CRC_INIT;
                    byte_cnt_d = '0;
`endif
                end else begin
                    txd_d = PREAMBLE_BYTE;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SFD, ST_DATA: begin
                txen_d = 1'b1;
                if (s_valid) begin
                    txd_d   = s_data;
                    state_d = ST_DATA;
`ifdef GMII_MAC_TX_FCS_EN
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_inc;
                    if (s_last) begin
                        state_d = (byte_cnt_inc < 11'(MIN_FRAME)) ? ST_PAD : ST_FCS;
                        cnt_d   = '0;
                    end
`else
                    if (s_last) begin
                        state_d = ST_IFG;
                        cnt_d   = '0;
                    end
`endif
                end else begin
                    txer_d  = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
`ifdef GMII_MAC_TX_FCS_EN
            ST_PAD: begin
                txen_d     = 1'b1;
                crc_d      = crc_next;
                byte_cnt_d = byte_cnt_inc;
                if (byte_cnt_inc >= 11'(MIN_FRAME)) begin
                    state_d = ST_FCS;
                    cnt_d   = '0;
                end
            end
            ST_FCS: begin
                txen_d = 1'b1;
                txd_d  = fcs_byte;
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = ST_IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            ST_IFG: begin
                if (cnt_q < 8'(IFG_BYTES)) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (s_valid) begin
                    state_d = ST_PREAMBLE;
                    txd_d   = PREAMBLE_BYTE;
                    txen_d  = 1'b1;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (s_valid && s_last) begin
                    state_d = ST_IFG;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            txd_q   <= '0;
            txen_q  <= 1'b0;
            txer_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            txen_q  <= txen_d;
            txer_q  <= txer_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

`ifdef GMII_MAC_TX_FCS_EN
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q      <= CRC_INIT;
            byte_cnt_q <= '0;
        end else begin
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_gmii_mac_tx.sv
// Self-checking bench for gmii_mac_tx; expected wire images come from a frame-level model.
// Honours GMII_MAC_TX_FCS_EN the same way as the design.
module tb_gmii_mac_tx;

    localparam int PRE  = 7;
    localparam int MINF = 60;
    localparam int IFG  = 12;
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef logic [7:0] bq_t[$];

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] txd;
    logic       txen;
    logic       txer;
    logic       gtx_clk;
    logic       busy;

    gmii_mac_tx #(
        .PREAMBLE_LEN (PRE),
        .MIN_FRAME    (MINF),
        .IFG_BYTES    (IFG)
    ) dut (
        .sys_clk (clk),
        .reset_n (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .txd     (txd),
        .txen    (txen),
        .txer    (txer),
        .gtx_clk (gtx_clk),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bq_t        src_d;
    bit         src_l[$];
    logic       tr_en[$];
    logic [7:0] tr_d[$];
    logic       tr_er[$];
    int         seg_s[$];
    int         seg_n[$];
    int         sidx;
    int         hold;
    int         drop_after;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_run(input logic [31:0] init, input bq_t b);
        logic [31:0] c;
        logic        fb;
        c = init;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ POLY;
            end
        end
        return c;
    endfunction

    function automatic int exp_len(input int n);
`ifdef GMII_MAC_TX_FCS_EN
        return PRE + 1 + ((n > MINF) ? n : MINF) + 4;
`else
        return PRE + 1 + n;
`endif
    endfunction

    function automatic bq_t wire_of(input bq_t p);
        bq_t         w;
        bq_t         body;
        logic [31:0] fcs;
        for (int i = 0; i < PRE; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        body = p;
`ifdef GMII_MAC_TX_FCS_EN
        while (body.size() < MINF) body.push_back(8'h00);
        fcs = ~crc_run(32'hFFFFFFFF, body);
        for (int i = 0; i < 4; i++) body.push_back(fcs[8*i +: 8]);
`else
        fcs = '0;
`endif
        foreach (body[i]) w.push_back(body[i]);
        return w;
    endfunction

    function automatic bq_t rand_frame(input int n);
        bq_t f;
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
        return f;
    endfunction

    task automatic push_frame(input bq_t f);
        foreach (f[i]) begin
            src_d.push_back(f[i]);
            src_l.push_back(i == f.size() - 1);
        end
    endtask

    task automatic drive_src();
        if (hold > 0) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            hold--;
        end else if (sidx < src_d.size()) begin
            s_valid = 1'b1;
            s_data  = src_d[sidx];
            s_last  = src_l[sidx];
        end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = 8'h00;
        end
    endtask

    // Runs the queued source bytes and records the wire until the link is quiet.
    // A non-negative rst_at pulses reset when that wire byte of the frame is on txd.
    task automatic run(input int rst_at);
        int quiet;
        int ncyc;
        int en_cnt;
        bit acc;
        tr_en.delete(); tr_d.delete(); tr_er.delete();
        sidx = 0; hold = 0; quiet = 0; ncyc = 0; en_cnt = 0;
        @(posedge clk); #1;
        drive_src();
        while (1) begin
            @(negedge clk);
            tr_en.push_back(txen);
            tr_d.push_back(txd);
            tr_er.push_back(txer);
            if (txen === 1'b1) en_cnt++;
            if (rst_at >= 0 && txen === 1'b1 && en_cnt - 1 == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_txen", txen, 1'b0);
                chk("rst_mid_txer", txer, 1'b0);
                chk("rst_mid_busy", busy, 1'b0);
                chk("rst_mid_ready", s_ready, 1'b0);
                break;
            end
            acc = (s_valid === 1'b1) && (s_ready === 1'b1);
            if (acc) begin
                sidx++;
                if (sidx == drop_after) hold = 2;
            end
            if (acc || txen === 1'b1) quiet = 0;
            else quiet++;
            if (sidx == src_d.size() && quiet >= IFG + 3) break;
            ncyc++;
            if (ncyc > 4000) begin
                checks++;
                errors++;
                $error("FAIL run_budget: got %0d cycles required at most 4000", ncyc);
                break;
            end
            @(posedge clk); #1;
            drive_src();
        end
        src_d.delete();
        src_l.delete();
    endtask

    task automatic analyze();
        seg_s.delete(); seg_n.delete();
        foreach (tr_en[i]) begin
            if (tr_en[i] === 1'b1) begin
                if (i == 0 || tr_en[i-1] !== 1'b1) begin
                    seg_s.push_back(i);
                    seg_n.push_back(0);
                end
                seg_n[seg_n.size()-1]++;
            end
        end
    endtask

    task automatic check_seg(input string tag, input int k, input int len, input bq_t exp);
        int mism;
        int ers;
        mism = 0;
        ers  = 0;
        chk({tag, "_len"}, seg_n[k], len);
        for (int j = 0; j < seg_n[k] && j < exp.size(); j++) begin
            if (tr_d[seg_s[k]+j] !== exp[j]) mism++;
            if (tr_er[seg_s[k]+j] !== 1'b0) ers++;
        end
        chk({tag, "_bytes_wrong"}, mism, 0);
        chk({tag, "_txer_cycles"}, ers, 0);
    endtask

    initial begin
        bq_t f;
        bq_t f2;
        bq_t body;
        bq_t exp;
        int  n;
        int  gap_nz;
        int  gap_end;

        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        drop_after = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_txen", txen, 1'b0);
        chk("reset_txer", txer, 1'b0);
        chk("reset_txd", txd, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", s_ready, 1'b0);
        rst_n = 1'b1;

        // 64-byte frame
        f = rand_frame(64);
        push_frame(f);
        run(-1);
        analyze();
        chk("f64_segments", seg_s.size(), 1);
        if (seg_s.size() >= 1) begin
            chk("f64_first_txen_cycle", seg_s[0], 1);
            check_seg("f64", 0, exp_len(64), wire_of(f));
`ifdef GMII_MAC_TX_FCS_EN
            body.delete();
            for (int j = PRE + 1; j < seg_n[0]; j++) body.push_back(tr_d[seg_s[0]+j]);
            chk("f64_crc_residue", crc_run(32'hFFFFFFFF, body), RESIDUE);
`endif
        end

        // "123456789"
        f.delete();
        for (int i = 0; i < 9; i++) f.push_back(8'h31 + 8'(i));
        push_frame(f);
        run(-1);
        analyze();
        chk("f9_segments", seg_s.size(), 1);
        if (seg_s.size() >= 1) check_seg("f9", 0, exp_len(9), wire_of(f));

        // single-byte frame
        f = rand_frame(1);
        push_frame(f);
        run(-1);
        analyze();
        chk("f1_segments", seg_s.size(), 1);
        if (seg_s.size() >= 1) check_seg("f1", 0, exp_len(1), wire_of(f));

        // random lengths straddling the minimum
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(2, 90));
            f = rand_frame(n);
            push_frame(f);
            run(-1);
            analyze();
            chk($sformatf("rnd%0d_n%0d_segments", r, n), seg_s.size(), 1);
            if (seg_s.size() >= 1) check_seg($sformatf("rnd%0d_n%0d", r, n), 0, exp_len(n), wire_of(f));
        end

        // back-to-back with s_valid held high
        f  = rand_frame(65);
        f2 = rand_frame(20);
        push_frame(f);
        push_frame(f2);
        run(-1);
        analyze();
        chk("b2b_segments", seg_s.size(), 2);
        if (seg_s.size() >= 2) begin
            check_seg("b2b_a", 0, exp_len(65), wire_of(f));
            check_seg("b2b_b", 1, exp_len(20), wire_of(f2));
            gap_end = seg_s[0] + seg_n[0];
            chk("b2b_gap_cycles", seg_s[1] - gap_end, IFG);
            gap_nz = 0;
            for (int j = gap_end; j < seg_s[1]; j++) if (tr_d[j] !== 8'h00) gap_nz++;
            chk("b2b_gap_nonzero_txd", gap_nz, 0);
        end

        // underrun after byte 20 of a 40-byte frame
        f = rand_frame(40);
        push_frame(f);
        drop_after = 20;
        run(-1);
        drop_after = -1;
        analyze();
        chk("urun_consumed", sidx, 40);
        chk("urun_segments", seg_s.size(), 1);
        if (seg_s.size() >= 1) begin
            exp.delete();
            for (int i = 0; i < PRE; i++) exp.push_back(8'h55);
            exp.push_back(8'hD5);
            for (int i = 0; i < 20; i++) exp.push_back(f[i]);
            exp.push_back(8'h00);
            chk("urun_len", seg_n[0], PRE + 1 + 20 + 1);
            n = 0;
            gap_nz = 0;
            for (int j = 0; j < seg_n[0] && j < exp.size(); j++) begin
                if (tr_d[seg_s[0]+j] !== exp[j]) n++;
                if (tr_er[seg_s[0]+j] === 1'b1) gap_nz++;
            end
            chk("urun_bytes_wrong", n, 0);
            chk("urun_txer_cycles", gap_nz, 1);
            chk("urun_txer_on_last", tr_er[seg_s[0]+seg_n[0]-1], 1'b1);
        end

        // reset pulse mid-frame (third FCS byte when FCS is built)
        f = rand_frame(64);
        push_frame(f);
`ifdef GMII_MAC_TX_FCS_EN
        run(PRE + 1 + 64 + 2);
`else
        run(40);
`endif
        s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_txen", txen, 1'b1);
        chk("post_rst_txd", txd, 8'h55);
        chk("post_rst_busy", busy, 1'b1);
        s_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gmii_mac_tx.md
# gmii_mac_tx

Transmit half of the GMII MAC; the counterpart to `GMII_MAC_RX` on the same 125 MHz byte-wide GMII link. Accepts an Ethernet frame as a byte stream (destination MAC through payload) from the loopback/filter path. Emits it on GMII as:

- preamble, SFD and frame bytes,
- zero padding up to the minimum frame size,
- CRC-32 FCS,
- enforced inter-frame gap.

## Interface

Parameters:
- `PREAMBLE_LEN`, 7: number of 0x55 bytes before the SFD.
- `MIN_FRAME`, 60: minimum bytes before the FCS; shorter frames are zero-padded.
- `IFG_BYTES`, 12: idle cycles enforced after every frame.

Ports:
- `sys_clk` input, 1: 125 MHz byte clock. One clock only.
- `reset_n` input, 1: reset, **asynchronous and active-low**.
- `s_data` input, 8: frame byte from upstream.
- `s_valid` input, 1: `s_data` valid.
- `s_last` input, 1: current byte is the last frame byte.
- `s_ready` output, 1: byte accepted on a cycle with `s_valid && s_ready`.
- `txd` output, 8: GMII transmit data.
- `txen` output, 1: GMII transmit enable.
- `txer` output, 1: GMII transmit error.
- `gtx_clk` output, 1: forwarded transmit clock, equal to `sys_clk`.
- `busy` output, 1: high in any state other than IDLE.

## Operation

- FSM states: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, DRAIN.
- IDLE: `s_valid` high goes to PREAMBLE. No byte is consumed.
- PREAMBLE: drives 0x55 for `PREAMBLE_LEN` cycles, then goes to SFD.
- SFD: drives 0xD5. `s_ready` is high in this cycle; the first byte accepted here appears on `txd` in the next cycle.
- DATA:
  - Each accepted byte is registered to `txd`, fed to the CRC and counted in an 11-bit byte counter that saturates at 2047.
  - On `s_last` accepted: go to PAD if count < `MIN_FRAME`, else to FCS.
- PAD: drives 0x00, included in the CRC, until count equals `MIN_FRAME`, then goes to FCS.
- FCS: drives 4 bytes of the complemented CRC register, least-significant byte first, then goes to IFG.
- IFG: `txen`=0 and `txd`=0x00 for `IFG_BYTES` cycles, then goes to IDLE.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Byte-wide update, LSB first.
  - Reset to init on entry to SFD.
- Underrun: `s_valid` low while in DATA (GMII cannot stall).
  - Drive `txen`=1, `txer`=1 and `txd`=0x00 for one cycle; no FCS is sent.
  - Then go to DRAIN.
- DRAIN: `s_ready`=1, discarding bytes until `s_last` is accepted, then go to IFG.
- `s_ready` is 0 in IDLE, PREAMBLE, PAD, FCS and IFG.

## Timing

- All outputs except `s_ready` and `gtx_clk` are registered.
- `s_ready` is a combinational decode of the state register only; it never depends on `s_valid`.
- Reset values: `txd`=0x00, `txen`=0, `txer`=0, `busy`=0, `s_ready`=0, state IDLE, counters 0, CRC 0xFFFFFFFF.
- Latency:
  - `s_valid` rises in IDLE at cycle 0.
  - `txen` is first seen high on the edge ending cycle 0.
  - SFD is on `txd` during cycle 8.
  - First payload byte is on `txd` during cycle 9.
- `txen` is continuous from the first preamble byte to the last FCS byte.
- Frame length on the wire: `PREAMBLE_LEN` + 1 + max(N, `MIN_FRAME`) + 4 cycles.
- Back-to-back frames: `s_valid` held high through IFG starts the next preamble on the cycle after IFG ends. Minimum spacing is exactly `IFG_BYTES` idle cycles.
- Single-byte frame (`s_last` on the first byte): padded with 59 zeros (`MIN_FRAME` − 1).
- `reset_n` asserted mid-frame:
  - `txen` and `txer` drop asynchronously.
  - State goes to IDLE; no IFG is enforced after reset.
  - The upstream frame remnant is not drained.

## Configuration

- `GMII_MAC_TX_FCS_EN` defined:
  - CRC generator, PAD and FCS states are built as described.
- `GMII_MAC_TX_FCS_EN` undefined:
  - No CRC logic, PAD or FCS states; DATA on `s_last` goes directly to IFG.
  - Upstream supplies any padding and FCS inside the stream.
  - Underrun and DRAIN behaviour is unchanged.

## Structure

- Shared package `gmii_mac_pkg` holds:
  - the state enumeration;
  - constants `PREAMBLE_BYTE` (0x55), `SFD_BYTE` (0xD5), `CRC_INIT` (0xFFFFFFFF), `CRC_POLY_REFL` (0xEDB88320) and `CRC_RESIDUE` (0xDEBB20E3);
  - all of these are shared with `GMII_MAC_RX`.
- One sub-module, `gmii_crc32_byte`:
  - combinational next-CRC from current CRC and one byte;
  - reused by the RX FCS checker.

## Test plan

- 64-byte frame, FCS on:
  - `txen` high for 76 cycles: 7 × 0x55, 0xD5, 64 bytes, 4 FCS bytes.
  - The bench recomputes the CRC over the 64 bytes plus the 4 FCS bytes; the result must equal `CRC_RESIDUE` 0xDEBB20E3.
- 9-byte frame "123456789":
  - bytes 10–60 on the wire are 0x00;
  - 4 FCS bytes follow byte 60;
  - `txen` high for 72 cycles.
- Two frames with `s_valid` held high: exactly 12 cycles of `txen`=0 and `txd`=0x00 between the last FCS byte and the next 0x55.
- Underrun: `s_valid` dropped after byte 20.
  - One cycle with `txen`=1, `txer`=1, `txd`=0x00, then `txen`=0.
  - Remaining bytes are consumed up to `s_last`.
  - No FCS is sent.
- `reset_n` pulsed low during FCS byte 2: `txen`=0 immediately; a new frame with `s_valid` starts preamble one cycle after `reset_n` deasserts.
- Macro undefined, 40-byte frame: `txen` high for exactly 48 cycles; no padding and no FCS.
